// File: rtl/reg_file_param.sv
// reg_file_param: parametrised register file, two registered read ports and
// one write port. A synchronous reset runs a counter-driven sweep that clears
// every register before `ready` rises. Optional register-0 hard-wiring via
// ZERO_REG.
// Build option: define RF_BYPASS_EN to forward same-edge write data to
// matching read ports. When it is undefined, a read during a write returns
// the old contents.
module reg_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr1,
  input  logic [ADDR_W-1:0]        rd_addr2,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  output logic signed [DATA_W-1:0] rd_data1,
  output logic signed [DATA_W-1:0] rd_data2,
  output logic                     ready
);

  localparam int NUM_REGS = 2**ADDR_W;
  localparam bit ZR       = (ZERO_REG != 0);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t                   state, state_n;
  logic [ADDR_W-1:0]        init_ptr;
  logic                     init_last;
  logic                     wr_ok;
  logic                     ready_n;
  logic signed [DATA_W-1:0] rd1_n, rd2_n;
  logic [DATA_W-1:0]        mem [NUM_REGS];

  assign init_last = (init_ptr == '1);
  // Writes to the hard-wired zero register are discarded.
  assign wr_ok     = wr_en && !(ZR && (wr_addr == '0));

  // Value presented by a read port for a given address on this edge.
  function automatic logic signed [DATA_W-1:0] port_val(input logic [ADDR_W-1:0] a);
    logic signed [DATA_W-1:0] v;
    if (ZR && (a == '0)) begin
      v = '0;
    end else begin
      v = mem[a];
    end
`ifdef RF_BYPASS_EN
    if (wr_ok && (a == wr_addr)) begin
      v = wr_data;
    end
`endif
    return v;
  endfunction

  // State, sweep counter and registered outputs; rst overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      init_ptr <= '0;
      ready    <= 1'b0;
      rd_data1 <= '0;
      rd_data2 <= '0;
    end else begin
      state    <= state_n;
      if (state == INIT) begin
        init_ptr <= init_ptr + 1'b1;
      end
      ready    <= ready_n;
      rd_data1 <= rd1_n;
      rd_data2 <= rd2_n;
    end
  end

  // Next state: leave INIT after the last register has been cleared.
  always_comb begin
    state_n = state;
    case (state)
      INIT:    if (init_last) state_n = RUN;
      RUN:     state_n = RUN;
      default: state_n = INIT;
    endcase
  end

  // Next values of the registered outputs; reads are ignored during INIT.
  always_comb begin
    ready_n = 1'b0;
    rd1_n   = rd_data1;
    rd2_n   = rd_data2;
    case (state)
      INIT: begin
        ready_n = init_last;
        rd1_n   = '0;
        rd2_n   = '0;
      end
      RUN: begin
        ready_n = 1'b1;
        if (rd_en) begin
          rd1_n = port_val(rd_addr1);
          rd2_n = port_val(rd_addr2);
        end
      end
      default: ready_n = 1'b0;
    endcase
  end

  // Array update: the sweep clears one entry per cycle, RUN applies writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        mem[init_ptr] <= '0;
      end else if (wr_ok) begin
        mem[wr_addr] <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param: a default instance (32x32, ZERO_REG=1)
// and a small instance (DATA_W=16, ADDR_W=3, ZERO_REG=0) share one clock.
module tb_reg_file_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string  nm;
    longint d1;
    longint d2;
  } exp_t;

  exp_t q_big[$];
  exp_t q_sml[$];

  // default instance
  logic               rst = 1'b1, rd_en = 1'b0, wr_en = 1'b0;
  logic [4:0]         rd_addr1 = '0, rd_addr2 = '0, wr_addr = '0;
  logic signed [31:0] wr_data = '0;
  logic signed [31:0] rd_data1, rd_data2;
  logic               ready;

  // small instance
  logic               s_rst = 1'b1, s_rd_en = 1'b0, s_wr_en = 1'b0;
  logic [2:0]         s_rd_addr1 = '0, s_rd_addr2 = '0, s_wr_addr = '0;
  logic signed [15:0] s_wr_data = '0;
  logic signed [15:0] s_rd_data1, s_rd_data2;
  logic               s_ready;

  reg_file_param u_dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .ready(ready)
  );

  reg_file_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) u_sml (
    .clk(clk), .rst(s_rst), .rd_en(s_rd_en), .rd_addr1(s_rd_addr1), .rd_addr2(s_rd_addr2),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .rd_data1(s_rd_data1), .rd_data2(s_rd_data2), .ready(s_ready)
  );

  function automatic void chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  // Monitors: a read strobe seen at an edge means new data is on the outputs.
  bit fire_big, fire_sml;
  always @(posedge clk) begin
    exp_t e;
    fire_big = rd_en;
    #1;
    if (fire_big) begin
      if (q_big.size() == 0) chk("big_sb_underflow", 1, 0);
      else begin
        e = q_big.pop_front();
        chk({e.nm, "_p1"}, rd_data1, e.d1);
        chk({e.nm, "_p2"}, rd_data2, e.d2);
      end
    end
  end

  always @(posedge clk) begin
    exp_t e;
    fire_sml = s_rd_en;
    #1;
    if (fire_sml) begin
      if (q_sml.size() == 0) chk("sml_sb_underflow", 1, 0);
      else begin
        e = q_sml.pop_front();
        chk({e.nm, "_p1"}, s_rd_data1, e.d1);
        chk({e.nm, "_p2"}, s_rd_data2, e.d2);
      end
    end
  end

  // Stimulus phase: inputs change 1 time unit after a rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input int d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2,
                    input longint e1, input longint e2, input string nm);
    rd_en = 1'b1; rd_addr1 = a1; rd_addr2 = a2;
    q_big.push_back('{nm, e1, e2});
    cyc();
    rd_en = 1'b0;
  endtask

  task automatic rdwr(input logic [4:0] a, input int d, input longint e, input string nm);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    rd_en = 1'b1; rd_addr1 = a; rd_addr2 = a;
    q_big.push_back('{nm, e, e});
    cyc();
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic s_wr(input logic [2:0] a, input int d);
    s_wr_en = 1'b1; s_wr_addr = a; s_wr_data = 16'(d);
    cyc();
    s_wr_en = 1'b0;
  endtask

  task automatic s_rd(input logic [2:0] a1, input logic [2:0] a2,
                      input longint e1, input longint e2, input string nm);
    s_rd_en = 1'b1; s_rd_addr1 = a1; s_rd_addr2 = a2;
    q_sml.push_back('{nm, e1, e2});
    cyc();
    s_rd_en = 1'b0;
  endtask

  // Edges from rst release until ready is seen, bounded.
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 100) begin
      cyc();
      n++;
    end
  endtask

  task automatic s_wait_ready(output int n);
    n = 0;
    while (!s_ready && n < 100) begin
      cyc();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rdw_exp;
    #1;
    // Init sweep with a write attempted during INIT
    cyc(); cyc();
    chk("rst_ready", ready, 0);
    chk("rst_rd1", rd_data1, 0);
    chk("rst_rd2", rd_data2, 0);
    rst = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd1; wr_data = 555;
    wait_ready(n);
    wr_en = 1'b0;
    chk("init_latency", n, 32);
    for (int i = 1; i < 32; i++) rd(5'(i), 5'(32 - i), 0, 0, "init_clear");

    // Basic write/read and hold
    wr(5'd1, 12996);
    wr(5'd3, -7070);
    rd(5'd1, 5'd3, 12996, -7070, "basic");
    cyc();
    chk("hold_rd1", rd_data1, 12996);
    chk("hold_rd2", rd_data2, -7070);

    // Zero register
    wr(5'd0, 16252);
    rd(5'd0, 5'd0, 0, 0, "zero_reg");

    // Read-during-write
    wr(5'd5, 3322);
`ifdef RF_BYPASS_EN
    rdw_exp = 5642;
`else
    rdw_exp = 3322;
`endif
    rdwr(5'd5, 5642, rdw_exp, "rdw_same_edge");
    rd(5'd5, 5'd5, 5642, 5642, "rdw_next");
    rdwr(5'd0, 999, 0, "rdw_zero");

    // Reset during RUN
    wr(5'd7, 6734);
    rd(5'd7, 5'd7, 6734, 6734, "r7_before_rst");
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("run_rst_ready", ready, 0);
    chk("run_rst_rd1", rd_data1, 0);
    chk("run_rst_rd2", rd_data2, 0);
    wait_ready(n);
    chk("run_rst_latency", n, 32);
    rd(5'd7, 5'd7, 0, 0, "r7_after_rst");

    // Reset at init_ptr == 10
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (10) cyc();
    chk("mid_init_ready", ready, 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    wait_ready(n);
    chk("mid_init_latency", n, 32);

    // Small instance: 8 registers, 16-bit, register 0 ordinary
    cyc();
    s_rst = 1'b0;
    s_wait_ready(n);
    chk("sml_latency", n, 8);
    s_wr(3'd7, 'h8000);
    s_rd(3'd7, 3'd7, -32768, -32768, "sml_signed");
    s_wr(3'(9), 1234);
    s_rd(3'd1, 3'd1, 1234, 1234, "sml_wrap");
    s_wr(3'd0, 16252);
    s_rd(3'd0, 3'd0, 16252, 16252, "sml_r0");

    cyc(); cyc();
    chk("big_sb_empty", q_big.size(), 0);
    chk("sml_sb_empty", q_sml.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
